// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator with a 2-entry valid/ready output buffer
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stat_cnt
);
  logic [1:0]       count_q, count_d;
  logic [31:0]      inst_q [2], inst_d [2];
  logic [XLEN-1:0]  imm_q  [2], imm_d  [2];
  logic [2:0]       fmt_q  [2], fmt_d  [2];
  logic             ill_q  [2], ill_d  [2];
  logic [CNT_W-1:0] stat_q, stat_d;
  logic [6:0]       op;
  logic [63:0]      s64, imm64;
  logic [2:0]       dec_fmt;
  logic             is_r, is_i, is_s, is_b, is_u, is_j, push, pop, wr;
  assign in_ready    = (count_q != 2'd2) && !flush;
  assign out_valid   = count_q != 2'd0;
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_inst    = inst_q[0];
  assign out_imm     = imm_q[0];
  assign out_fmt     = fmt_q[0];
  assign out_illegal = ill_q[0];
  assign stat_cnt    = stat_q;
  // Classify the opcode and build the immediate at 64 bits, truncated to XLEN on write
  always_comb begin
    op      = in_inst[6:0];
    s64     = {64{in_inst[31]}};
    is_r    = op == 7'h33 || (op == 7'h3B && XLEN == 64);
    is_i    = op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73 || (op == 7'h1B && XLEN == 64);
    is_s    = op == 7'h23;
    is_b    = op == 7'h63;
    is_u    = op == 7'h37 || op == 7'h17;
    is_j    = op == 7'h6F;
    dec_fmt = is_r ? 3'd0 : is_i ? 3'd1 : is_s ? 3'd2 : is_b ? 3'd3 : is_u ? 3'd4 : is_j ? 3'd5 : 3'd7;
    imm64   = is_i ? {s64[63:12], in_inst[31:20]} :
              is_s ? {s64[63:12], in_inst[31:25], in_inst[11:7]} :
              is_b ? {s64[63:12], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
              is_u ? {s64[63:32], in_inst[31:12], 12'h000} :
              is_j ? {s64[63:20], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} : 64'd0;
  end
  // FIFO next state: entry 0 is always the head, pop shifts, push fills the first free slot
  always_comb begin
    count_d = count_q;
    inst_d  = inst_q;
    imm_d   = imm_q;
    fmt_d   = fmt_q;
    ill_d   = ill_q;
    stat_d  = stat_q + CNT_W'(push);
    wr      = !(count_q == 2'd0 || pop);
    if (flush) begin
      count_d = 2'd0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        inst_d[0] = inst_q[1];
        imm_d[0]  = imm_q[1];
        fmt_d[0]  = fmt_q[1];
        ill_d[0]  = ill_q[1];
      end
      if (push) begin
        inst_d[wr] = in_inst;
        imm_d[wr]  = imm64[XLEN-1:0];
        fmt_d[wr]  = dec_fmt;
        ill_d[wr]  = dec_fmt == 3'd7;
      end
    end
  end
  // State registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      inst_q  <= '{default: '0};
      imm_q   <= '{default: '0};
      fmt_q   <= '{default: '0};
      ill_q   <= '{default: '0};
      stat_q  <= '0;
    end else begin
      count_q <= count_d;
      inst_q  <= inst_d;
      imm_q   <= imm_d;
      fmt_q   <= fmt_d;
      ill_q   <= ill_d;
      stat_q  <= stat_d;
    end
  end
endmodule
